// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 8-digit common-anode 7-segment scanner with double-buffered value and blanking gap
module seg7_scan_ctrl #(
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        load_i,
    input  logic [31:0] data_i,
    input  logic [7:0]  dp_i,
    input  logic [7:0]  en_i,
    output logic        frame_o,
    output logic [7:0]  display,
    output logic [7:0]  Anode
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [47:0]   pend_q, pend_d, act_q, act_d;
    logic          pend_flag_q, pend_flag_d;
    logic [7:0]    anode_q, anode_d, display_q, display_d;
    logic [47:0]   in_bundle;
    logic [31:0]   act_data;
    logic [7:0]    act_dp, act_en;
    logic [3:0]    nib;
    logic          lit;

    // bundles are packed {en, dp, data}
    assign in_bundle = {en_i, dp_i, data_i};
    assign act_data  = act_q[31:0];
    assign act_dp    = act_q[39:32];
    assign act_en    = act_q[47:40];
    assign Anode     = anode_q;
    assign display   = display_q;

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        idx_d       = idx_q;
        pend_d      = pend_q;
        pend_flag_d = pend_flag_q;
        act_d       = act_q;
        frame_o     = 1'b0;
        nib         = act_data[{idx_q, 2'b00} +: 4];
        lit         = (state_q == SHOW) && act_en[idx_q];
        anode_d     = lit ? ~(8'd1 << idx_q) : 8'hFF;
        display_d   = lit ? {~act_dp[idx_q], seg(nib)} : 8'hFF;
        if (state_q == BLANK && cnt_q == BLANK_LAST)
            state_d = SHOW;
        if (state_q == SHOW && cnt_q == SLOT_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = idx_q + 3'd1;
            frame_o = (idx_q == 3'd7);
        end
        if (load_i) begin
            pend_d      = in_bundle;
            pend_flag_d = 1'b1;
        end
        // a load landing on the boundary bypasses the pending buffer
        if (frame_o) begin
            act_d       = load_i ? in_bundle : (pend_flag_q ? pend_q : act_q);
            pend_flag_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= BLANK;
            cnt_q       <= '0;
            idx_q       <= '0;
            pend_q      <= '0;
            pend_flag_q <= 1'b0;
            act_q       <= '0;
            anode_q     <= 8'hFF;
            display_q   <= 8'hFF;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            pend_flag_q <= pend_flag_d;
            act_q       <= act_d;
            anode_q     <= anode_d;
            display_q   <= display_d;
        end
    end
endmodule
